// File: rtl/sr_chain_seq.sv
// Sequencer for a two-phase latch shift-register chain: non-overlapping phi1/phi2,
// LSB-first byte serialiser/deserialiser, and a tag shadow that filters out bubbles.
module sr_chain_seq #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned GAP   = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_in_data,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  input  logic       i_flush,
  output logic [7:0] o_out_data,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic       o_phi1,
  output logic       o_phi2,
  output logic       o_sr_in,
  input  logic       i_sr_out,
  output logic       o_busy
);

  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GapLast = GW'(GAP - 1);

  typedef enum logic [2:0] {StIdle, StPh1, StG1, StPh2, StG2} state_e;

  state_e           r_state;
  logic [GW-1:0]    r_gap_cnt;
  logic             r_phi1;
  logic             r_phi2;
  logic             r_sr_in;
  logic [DEPTH-1:0] r_shadow;

  logic [7:0]       r_ser_reg;
  logic [3:0]       r_ser_cnt;
  logic             r_in_ready;

  logic [6:0]       r_deser;
  logic [2:0]       r_deser_cnt;
  logic [7:0]       r_out_data;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_have_data;
  logic             w_last_g2;
  logic             w_sample;
  logic             w_complete;
  logic [2:0]       w_deser_cnt_next;
  logic             w_stall;
  logic             w_start;
  logic [DEPTH-1:0] w_shadow_shift;

  assign w_accept    = i_in_valid & r_in_ready;
  assign w_have_data = (r_ser_cnt != 4'd0);
  assign w_last_g2   = (r_state == StG2) && (r_gap_cnt == '0);
  assign w_sample    = w_last_g2 & r_shadow[DEPTH-1];
  assign w_complete  = w_sample & (r_deser_cnt == 3'd7);

  always_comb begin
    w_deser_cnt_next = r_deser_cnt;
    if (w_sample) begin
      w_deser_cnt_next = w_complete ? 3'd0 : r_deser_cnt + 3'd1;
    end
  end

  // Use the post-sample count: a step may start on the same edge that samples bit 7 of 8.
  assign w_stall = (w_deser_cnt_next == 3'd7) & r_out_valid & ~i_out_ready;
  assign w_start = ((r_state == StIdle) | w_last_g2) & (w_have_data | i_flush) & ~w_stall;

  if (DEPTH > 1) begin : g_shadow_multi
    assign w_shadow_shift = {r_shadow[DEPTH-2:0], w_have_data};
  end else begin : g_shadow_single
    assign w_shadow_shift = w_have_data;
  end

  // Step FSM; the last G2 cycle doubles as the step boundary so back-to-back steps
  // take 2+2*GAP cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_gap_cnt <= '0;
      r_phi1    <= 1'b0;
      r_phi2    <= 1'b0;
      r_sr_in   <= 1'b0;
      r_shadow  <= '0;
    end else begin
      case (r_state)
        StPh1: begin
          r_state   <= StG1;
          r_phi1    <= 1'b0;
          r_gap_cnt <= GapLast;
        end
        StG1: begin
          if (r_gap_cnt == '0) begin
            r_state <= StPh2;
            r_phi2  <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt - GW'(1);
          end
        end
        StPh2: begin
          r_state   <= StG2;
          r_phi2    <= 1'b0;
          r_gap_cnt <= GapLast;
        end
        default: begin
          if ((r_state == StG2) && (r_gap_cnt != '0)) begin
            r_gap_cnt <= r_gap_cnt - GW'(1);
          end else if (w_start) begin
            r_state  <= StPh1;
            r_phi1   <= 1'b1;
            r_sr_in  <= w_have_data & r_ser_reg[0];
            r_shadow <= w_shadow_shift;
          end else begin
            r_state <= StIdle;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ser_reg  <= 8'd0;
      r_ser_cnt  <= 4'd0;
      r_in_ready <= 1'b0;
    end else if (w_accept) begin
      r_ser_reg  <= i_in_data;
      r_ser_cnt  <= 4'd8;
      r_in_ready <= 1'b0;
    end else if (w_start && w_have_data) begin
      r_ser_reg  <= {1'b0, r_ser_reg[7:1]};
      r_ser_cnt  <= r_ser_cnt - 4'd1;
      r_in_ready <= (r_ser_cnt == 4'd1);
    end else begin
      r_in_ready <= (r_ser_cnt == 4'd0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_deser     <= 7'd0;
      r_deser_cnt <= 3'd0;
      r_out_data  <= 8'd0;
      r_out_valid <= 1'b0;
    end else begin
      r_deser_cnt <= w_deser_cnt_next;
      if (w_sample && !w_complete) begin
        r_deser[r_deser_cnt] <= i_sr_out;
      end
      if (w_complete) begin
        r_out_data  <= {i_sr_out, r_deser};
        r_out_valid <= 1'b1;
      end else if (r_out_valid && i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_phi1      = r_phi1;
  assign o_phi2      = r_phi2;
  assign o_sr_in     = r_sr_in;
  assign o_busy      = w_have_data | (|r_shadow) | (r_deser_cnt != 3'd0) | r_out_valid;

endmodule
